// File: rtl/segment_scan_if.sv
// Handshake and display bus of the 1A2B seven-segment scan controller.
//   guess_valid/guess_ready/guess_digits : guess source, four BCD digits
//                                          ([15:12] leftmost .. [3:0] rightmost)
//   result_valid/result_ready/result_a/b : score source, "xAyB" counts
//   AN  : anode enables, active-low, one-hot-low
//   SEG : segments {a,b,c,d,e,f,g}, active-low
// master = requesters and display (environment side), slave = controller.
interface segment_scan_if;
  logic        guess_valid;
  logic        guess_ready;
  logic [15:0] guess_digits;
  logic        result_valid;
  logic        result_ready;
  logic [3:0]  result_a;
  logic [3:0]  result_b;
  logic [3:0]  AN;
  logic [6:0]  SEG;

  modport master (
    output guess_valid, guess_digits, result_valid, result_a, result_b,
    input  guess_ready, result_ready, AN, SEG
  );

  modport slave (
    input  guess_valid, guess_digits, result_valid, result_a, result_b,
    output guess_ready, result_ready, AN, SEG
  );
endinterface

// File: rtl/segment_scan_controller.sv
// Four-digit seven-segment scan controller for the 1A2B game.
// Arbitrates between a guess source and a result source (valid/ready each),
// latches the winning content and multiplexes it over the four anodes.
// A result preempts the guess for HOLD_FRAMES full scan frames.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : segment_scan_if.slave (handshakes, AN, SEG)
// Parameters:
//   REFRESH_DIV : clk cycles per digit slot (>= 2)
//   HOLD_FRAMES : scan frames a result stays on screen (>= 1)
module segment_scan_controller #(
  parameter int REFRESH_DIV = 100000,
  parameter int HOLD_FRAMES = 200
) (
  input  logic          clk,
  input  logic          rst,
  segment_scan_if.slave bus
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_FRAMES - 1);

  localparam logic [6:0] SEG_BLANK   = 7'b1111111;
  localparam logic [6:0] SEG_GLYPH_A = 7'b0001000;
  localparam logic [6:0] SEG_GLYPH_B = 7'b1100000;

  typedef enum logic {
    SHOW_GUESS,
    SHOW_RESULT
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [1:0]      scan_idx_q, scan_idx_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [15:0]     guess_q;
  logic [3:0]      res_a_q;
  logic [3:0]      res_b_q;

  logic            tick;
  logic            frame_end;
  logic            result_xfer;
  logic [6:0]      seg_p0;
  logic [3:0]      an_p1;
  logic [6:0]      seg_p1;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Readiness is combinational so it drops in the very cycle rst is high.
  assign bus.guess_ready  = ~rst;
  assign bus.result_ready = ~rst && (state_q == SHOW_GUESS);

  assign tick        = (presc_q == PRESC_MAX);
  assign frame_end   = tick && (scan_idx_q == 2'd3);
  assign result_xfer = bus.result_valid && bus.result_ready;

  always_comb begin
    state_d    = state_q;
    presc_d    = tick ? '0 : presc_q + 1'b1;
    scan_idx_d = tick ? scan_idx_q + 2'd1 : scan_idx_q;
    hold_d     = hold_q;
    case (state_q)
      SHOW_GUESS: begin
        // A new result restarts the scan so it is shown from digit 0 for
        // exactly HOLD_FRAMES whole frames.
        if (result_xfer) begin
          state_d    = SHOW_RESULT;
          presc_d    = '0;
          scan_idx_d = 2'd0;
          hold_d     = '0;
        end
      end
      SHOW_RESULT: begin
        if (frame_end) begin
          if (hold_q == HOLD_MAX) begin
            state_d = SHOW_GUESS;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: state_d = SHOW_GUESS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SHOW_GUESS;
      presc_q    <= '0;
      scan_idx_q <= 2'd0;
      hold_q     <= '0;
      guess_q    <= 16'hFFFF;
      res_a_q    <= 4'd0;
      res_b_q    <= 4'd0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      scan_idx_q <= scan_idx_d;
      hold_q     <= hold_d;
      // Guesses are accepted in either state; during a result they wait
      // silently in the register until the display reverts.
      if (bus.guess_valid)
        guess_q <= bus.guess_digits;
      if (result_xfer) begin
        res_a_q <= bus.result_a;
        res_b_q <= bus.result_b;
      end
    end
  end

  // Stage p0: select and decode the digit under the current scan index.
  always_comb begin
    seg_p0 = SEG_BLANK;
    if (state_q == SHOW_GUESS) begin
      case (scan_idx_q)
        2'd0:    seg_p0 = seg_decode(guess_q[3:0]);
        2'd1:    seg_p0 = seg_decode(guess_q[7:4]);
        2'd2:    seg_p0 = seg_decode(guess_q[11:8]);
        default: seg_p0 = seg_decode(guess_q[15:12]);
      endcase
    end else begin
      case (scan_idx_q)
        2'd0:    seg_p0 = SEG_GLYPH_B;
        2'd1:    seg_p0 = seg_decode(res_b_q);
        2'd2:    seg_p0 = SEG_GLYPH_A;
        default: seg_p0 = seg_decode(res_a_q);
      endcase
    end
  end

  // Stage p1: AN and SEG registered together so the pins never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_p1  <= 4'b1111;
      seg_p1 <= SEG_BLANK;
    end else begin
      an_p1  <= ~(4'b0001 << scan_idx_q);
      seg_p1 <= seg_p0;
    end
  end

  assign bus.AN  = an_p1;
  assign bus.SEG = seg_p1;

endmodule

// File: tb/tb_segment_scan_controller.sv
// Directed bench for segment_scan_controller with REFRESH_DIV=4,
// HOLD_FRAMES=2 (one digit slot = 4 cycles, one result hold = 32 cycles).
module tb_segment_scan_controller;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  segment_scan_if bus ();

  segment_scan_controller #(
    .REFRESH_DIV (4),
    .HOLD_FRAMES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000 ns");
    $fatal(1, "watchdog expired");
  end

  // Advances on negedges until AN matches, at most budget cycles.
  task automatic wait_an(input logic [3:0] want, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.AN === want) begin
        found = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.AN !== 4'b1111) begin
      n_fail++; $display("FAIL reset_an: got %b expected %b", bus.AN, 4'b1111);
    end
    n_cmp++;
    if (bus.SEG !== 7'b1111111) begin
      n_fail++; $display("FAIL reset_seg: got %b expected %b", bus.SEG, 7'b1111111);
    end
    n_cmp++;
    if (bus.guess_ready !== 1'b0 || bus.result_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b%b expected 00", bus.guess_ready, bus.result_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    logic [3:0] exp_an;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      exp_an = ~(4'b0001 << (((k - 1) / 4) % 4));
      n_cmp++;
      if (bus.AN !== exp_an) begin
        n_fail++; $display("FAIL idle_an k=%0d: got %b expected %b", k, bus.AN, exp_an);
      end
      n_cmp++;
      if (bus.SEG !== 7'b1111111) begin
        n_fail++; $display("FAIL idle_seg k=%0d: got %b expected %b", k, bus.SEG, 7'b1111111);
      end
      n_cmp++;
      if (bus.guess_ready !== 1'b1 || bus.result_ready !== 1'b1) begin
        n_fail++; $display("FAIL idle_ready k=%0d: got %b%b expected 11", k, bus.guess_ready, bus.result_ready);
      end
    end
  endtask

  task automatic test_guess();
    logic [6:0] exp_seg [4];
    logic [3:0] an;
    bit         found;
    // 16'h1234: idx0='4', idx1='3', idx2='2', idx3='1'
    exp_seg[0] = 7'b1001100;
    exp_seg[1] = 7'b0000110;
    exp_seg[2] = 7'b0010010;
    exp_seg[3] = 7'b1001111;
    bus.guess_valid  = 1'b1;
    bus.guess_digits = 16'h1234;
    @(negedge clk);
    bus.guess_valid = 1'b0;
    @(negedge clk);
    for (int i = 3; i >= 0; i--) begin
      an = ~(4'b0001 << i);
      wait_an(an, 20, found);
      n_cmp++;
      if (!found) begin
        n_fail++; $display("FAIL guess1234_an: AN never reached %b, last %b", an, bus.AN);
      end
      n_cmp++;
      if (bus.SEG !== exp_seg[i]) begin
        n_fail++; $display("FAIL guess1234_seg AN=%b: got %b expected %b", an, bus.SEG, exp_seg[i]);
      end
    end
    // 16'hA0F9: idx0='9', idx1 blank, idx2='0', idx3 blank
    exp_seg[0] = 7'b0000100;
    exp_seg[1] = 7'b1111111;
    exp_seg[2] = 7'b0000001;
    exp_seg[3] = 7'b1111111;
    bus.guess_valid  = 1'b1;
    bus.guess_digits = 16'hA0F9;
    @(negedge clk);
    bus.guess_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      an = ~(4'b0001 << i);
      wait_an(an, 20, found);
      n_cmp++;
      if (!found) begin
        n_fail++; $display("FAIL guessA0F9_an: AN never reached %b, last %b", an, bus.AN);
      end
      n_cmp++;
      if (bus.SEG !== exp_seg[i]) begin
        n_fail++; $display("FAIL guessA0F9_seg AN=%b: got %b expected %b", an, bus.SEG, exp_seg[i]);
      end
    end
  endtask

  task automatic test_result();
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an;
    int         idx;
    // a=2, b=1: idx0='b', idx1='1', idx2='A', idx3='2'
    exp_seg[0] = 7'b1100000;
    exp_seg[1] = 7'b1001111;
    exp_seg[2] = 7'b0001000;
    exp_seg[3] = 7'b0010010;
    n_cmp++;
    if (bus.result_ready !== 1'b1) begin
      n_fail++; $display("FAIL result_ready_before: got %b expected 1", bus.result_ready);
    end
    bus.result_valid = 1'b1;
    bus.result_a     = 4'd2;
    bus.result_b     = 4'd1;
    @(negedge clk);
    bus.result_valid = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      idx    = ((k - 1) / 4) % 4;
      exp_an = ~(4'b0001 << idx);
      n_cmp++;
      if (bus.AN !== exp_an || bus.SEG !== exp_seg[idx]) begin
        n_fail++; $display("FAIL result21_disp k=%0d: got %b/%b expected %b/%b", k, bus.AN, bus.SEG, exp_an, exp_seg[idx]);
      end
      n_cmp++;
      if (bus.result_ready !== (k == 32)) begin
        n_fail++; $display("FAIL result21_ready k=%0d: got %b expected %b", k, bus.result_ready, (k == 32));
      end
    end
    @(negedge clk);
    n_cmp++;
    if (bus.AN !== 4'b1110 || bus.SEG !== 7'b0000100) begin
      n_fail++; $display("FAIL result21_revert: got %b/%b expected 1110/0000100", bus.AN, bus.SEG);
    end
  endtask

  task automatic test_stall();
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an;
    int         idx;
    // first result a=3, b=0
    exp_seg[0] = 7'b1100000;
    exp_seg[1] = 7'b0000001;
    exp_seg[2] = 7'b0001000;
    exp_seg[3] = 7'b0000110;
    bus.result_valid = 1'b1;
    bus.result_a     = 4'd3;
    bus.result_b     = 4'd0;
    @(negedge clk);
    bus.result_valid = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      idx    = ((k - 1) / 4) % 4;
      exp_an = ~(4'b0001 << idx);
      n_cmp++;
      if (bus.AN !== exp_an || bus.SEG !== exp_seg[idx]) begin
        n_fail++; $display("FAIL stall_first_disp k=%0d: got %b/%b expected %b/%b", k, bus.AN, bus.SEG, exp_an, exp_seg[idx]);
      end
      n_cmp++;
      if (bus.result_ready !== (k == 32)) begin
        n_fail++; $display("FAIL stall_ready k=%0d: got %b expected %b", k, bus.result_ready, (k == 32));
      end
      if (k == 5) begin
        bus.guess_valid  = 1'b1;
        bus.guess_digits = 16'h5678;
      end else begin
        bus.guess_valid = 1'b0;
      end
      if (k == 6) begin
        bus.result_valid = 1'b1;
        bus.result_a     = 4'd4;
        bus.result_b     = 4'd4;
      end
    end
    // Held result is accepted on the reversion edge; that edge still shows
    // the silently latched guess digit0 '8'.
    @(negedge clk);
    bus.result_valid = 1'b0;
    n_cmp++;
    if (bus.AN !== 4'b1110 || bus.SEG !== 7'b0000000) begin
      n_fail++; $display("FAIL stall_gap_guess: got %b/%b expected 1110/0000000", bus.AN, bus.SEG);
    end
    // second result a=4, b=4
    exp_seg[1] = 7'b1001100;
    exp_seg[3] = 7'b1001100;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      idx    = ((k - 1) / 4) % 4;
      exp_an = ~(4'b0001 << idx);
      n_cmp++;
      if (bus.AN !== exp_an || bus.SEG !== exp_seg[idx]) begin
        n_fail++; $display("FAIL stall_second_disp k=%0d: got %b/%b expected %b/%b", k, bus.AN, bus.SEG, exp_an, exp_seg[idx]);
      end
      n_cmp++;
      if (bus.result_ready !== (k == 32)) begin
        n_fail++; $display("FAIL stall_second_ready k=%0d: got %b expected %b", k, bus.result_ready, (k == 32));
      end
    end
    @(negedge clk);
    n_cmp++;
    if (bus.AN !== 4'b1110 || bus.SEG !== 7'b0000000) begin
      n_fail++; $display("FAIL stall_revert: got %b/%b expected 1110/0000000", bus.AN, bus.SEG);
    end
  endtask

  task automatic test_simultaneous();
    logic [6:0] exp_seg [4];
    logic [6:0] exp_gseg [4];
    logic [3:0] exp_an;
    int         idx;
    // result a=1, b=3
    exp_seg[0] = 7'b1100000;
    exp_seg[1] = 7'b0000110;
    exp_seg[2] = 7'b0001000;
    exp_seg[3] = 7'b1001111;
    // guess 16'h9876: idx0='6', idx1='7', idx2='8', idx3='9'
    exp_gseg[0] = 7'b0100000;
    exp_gseg[1] = 7'b0001111;
    exp_gseg[2] = 7'b0000000;
    exp_gseg[3] = 7'b0000100;
    bus.guess_valid  = 1'b1;
    bus.guess_digits = 16'h9876;
    bus.result_valid = 1'b1;
    bus.result_a     = 4'd1;
    bus.result_b     = 4'd3;
    @(negedge clk);
    bus.guess_valid  = 1'b0;
    bus.result_valid = 1'b0;
    for (int k = 1; k <= 48; k++) begin
      @(negedge clk);
      if (k <= 32) begin
        idx    = ((k - 1) / 4) % 4;
        exp_an = ~(4'b0001 << idx);
        n_cmp++;
        if (bus.AN !== exp_an || bus.SEG !== exp_seg[idx]) begin
          n_fail++; $display("FAIL simul_result_disp k=%0d: got %b/%b expected %b/%b", k, bus.AN, bus.SEG, exp_an, exp_seg[idx]);
        end
      end else begin
        idx    = (k - 33) / 4;
        exp_an = ~(4'b0001 << idx);
        n_cmp++;
        if (bus.AN !== exp_an || bus.SEG !== exp_gseg[idx]) begin
          n_fail++; $display("FAIL simul_guess_disp k=%0d: got %b/%b expected %b/%b", k, bus.AN, bus.SEG, exp_an, exp_gseg[idx]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    bus.result_valid = 1'b1;
    bus.result_a     = 4'd2;
    bus.result_b     = 4'd2;
    @(negedge clk);
    bus.result_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.AN !== 4'b1111 || bus.SEG !== 7'b1111111) begin
      n_fail++; $display("FAIL midreset_out: got %b/%b expected 1111/1111111", bus.AN, bus.SEG);
    end
    n_cmp++;
    if (bus.result_ready !== 1'b0 || bus.guess_ready !== 1'b0) begin
      n_fail++; $display("FAIL midreset_ready_in_rst: got %b%b expected 00", bus.guess_ready, bus.result_ready);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.result_ready !== 1'b1 || bus.guess_ready !== 1'b1) begin
      n_fail++; $display("FAIL midreset_ready_after: got %b%b expected 11", bus.guess_ready, bus.result_ready);
    end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.AN !== ~(4'b0001 << ((k - 1) / 4)) || bus.SEG !== 7'b1111111) begin
        n_fail++; $display("FAIL midreset_blank k=%0d: got %b/%b expected %b/1111111", k, bus.AN, bus.SEG, ~(4'b0001 << ((k - 1) / 4)));
      end
    end
  endtask

  initial begin
    n_cmp            = 0;
    n_fail           = 0;
    rst              = 1'b1;
    bus.guess_valid  = 1'b0;
    bus.guess_digits = 16'h0000;
    bus.result_valid = 1'b0;
    bus.result_a     = 4'd0;
    bus.result_b     = 4'd0;
    @(negedge clk);
    test_reset();
    test_idle();
    test_guess();
    test_result();
    test_stall();
    test_simultaneous();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
